// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared note/state types and tone divider table for the piano front end
package piano_pkg;

  typedef enum logic [2:0] {
    NOTE_C    = 3'd0,
    NOTE_D    = 3'd1,
    NOTE_E    = 3'd2,
    NOTE_F    = 3'd3,
    NOTE_G    = 3'd4,
    NOTE_A    = 3'd5,
    NOTE_B    = 3'd6,
    NOTE_NONE = 3'd7
  } note_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int NUM_NOTES = 7;
  localparam int DIV_W     = 17;

  // Half-period counts at 50 MHz for octave 0 (C4..B4).
  function automatic logic [DIV_W-1:0] base_div(input note_e n);
    logic [DIV_W-1:0] d;
    case (n)
      NOTE_C:  d = 17'd95556;
      NOTE_D:  d = 17'd85131;
      NOTE_E:  d = 17'd75843;
      NOTE_F:  d = 17'd71586;
      NOTE_G:  d = 17'd63776;
      NOTE_A:  d = 17'd56818;
      NOTE_B:  d = 17'd50619;
      default: d = 17'd0;
    endcase
    return d;
  endfunction

  // Lowest held note index wins; NOTE_NONE when nothing is held.
  function automatic note_e prio_winner(input logic [NUM_NOTES-1:0] keys);
    note_e w;
    w = NOTE_NONE;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (keys[i]) w = note_e'(3'(i));
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser followed by a stable-count debouncer
module key_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_deb
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEB_CYCLES straight cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
      r_deb <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/piano_note_arbiter.sv
// rtl/piano_note_arbiter.sv - key debounce, single-note arbitration and octave register; PIANO_SUSTAIN_EN adds a release hold
import piano_pkg::*;

module piano_note_arbiter #(
  parameter int DEB_CYCLES     = 50000,
  parameter int OCT_MAX        = 3,
  parameter int OCT_RESET      = 0,
  parameter int SUSTAIN_CYCLES = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_c,
  input  logic        key_d,
  input  logic        key_e,
  input  logic        key_f,
  input  logic        key_g,
  input  logic        key_a,
  input  logic        key_b,
  input  logic        up,
  input  logic        down,
  output logic        note_valid,
  output logic [2:0]  note_code,
  output logic        note_start,
  output logic [1:0]  octave,
  output logic [16:0] tone_div
);

  logic [8:0]       w_raw;
  logic [8:0]       w_deb;
  logic [6:0]       w_keys;
  logic             w_up;
  logic             w_dn;
  logic             w_up_rise;
  logic             w_dn_rise;
  logic             w_any;
  logic             w_latched_held;
  note_e            w_winner;

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  note_e            r_code;
  note_e            w_code_next;
  logic             r_valid;
  logic             w_valid_next;
  logic             r_start;
  logic             w_start_next;
  logic [1:0]       r_octave;
  logic [1:0]       w_oct_next;
  logic [16:0]      r_tone_div;
  logic [16:0]      w_div_next;
  logic             r_up_d;
  logic             r_dn_d;

`ifdef PIANO_SUSTAIN_EN
  localparam int SUS_W = $clog2(SUSTAIN_CYCLES + 1);
  logic [SUS_W-1:0] r_sus_cnt;
  logic [SUS_W-1:0] w_sus_next;
`endif

  assign w_raw = {down, up, key_b, key_a, key_g, key_f, key_e, key_d, key_c};

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_deb
      key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_raw (w_raw[gi]),
        .o_deb (w_deb[gi])
      );
    end
  endgenerate

  assign w_keys         = w_deb[6:0];
  assign w_up           = w_deb[7];
  assign w_dn           = w_deb[8];
  assign w_up_rise      = w_up & ~r_up_d;
  assign w_dn_rise      = w_dn & ~r_dn_d;
  assign w_any          = |w_keys;
  assign w_winner       = prio_winner(w_keys);
  // Padding bit makes NOTE_NONE index a never-held slot.
  assign w_latched_held = ({1'b0, w_keys} >> r_code) != 8'd0 ? ({1'b0, w_keys} >> r_code) & 8'd1 ? 1'b1 : 1'b0 : 1'b0;

  // Octave steps once per debounced rising edge; simultaneous up/down cancel.
  always_comb begin
    w_oct_next = r_octave;
    if (w_up_rise && !w_dn_rise && (r_octave != 2'(OCT_MAX))) begin
      w_oct_next = r_octave + 2'd1;
    end else if (w_dn_rise && !w_up_rise && (r_octave != 2'd0)) begin
      w_oct_next = r_octave - 2'd1;
    end
  end

  // Arbitration FSM: latch one winner, no stealing, re-arbitrate when it is released.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_valid_next = r_valid;
    w_start_next = 1'b0;
`ifdef PIANO_SUSTAIN_EN
    w_sus_next   = '0;
`endif
    case (r_state)
      IDLE: begin
        w_code_next  = NOTE_NONE;
        w_valid_next = 1'b0;
        if (w_any) begin
          w_state_next = ACTIVE;
          w_code_next  = w_winner;
          w_valid_next = 1'b1;
          w_start_next = 1'b1;
        end
      end
      ACTIVE: begin
        if (!w_latched_held) begin
          if (w_any) begin
            w_code_next  = w_winner;
            w_start_next = 1'b1;
          end else begin
`ifdef PIANO_SUSTAIN_EN
            w_state_next = RELEASE;
`else
            w_state_next = IDLE;
            w_code_next  = NOTE_NONE;
            w_valid_next = 1'b0;
`endif
          end
        end
      end
      RELEASE: begin
`ifdef PIANO_SUSTAIN_EN
        if (w_any) begin
          w_state_next = ACTIVE;
          w_code_next  = w_winner;
          w_valid_next = 1'b1;
          w_start_next = 1'b1;
        end else if (r_sus_cnt == SUS_W'(SUSTAIN_CYCLES - 1)) begin
          w_state_next = IDLE;
          w_code_next  = NOTE_NONE;
          w_valid_next = 1'b0;
        end else begin
          w_sus_next   = r_sus_cnt + 1'b1;
        end
`else
        w_state_next = IDLE;
        w_code_next  = NOTE_NONE;
        w_valid_next = 1'b0;
`endif
      end
      default: begin
        w_state_next = IDLE;
        w_code_next  = NOTE_NONE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  // Divider follows both the note and the octave that will be registered this edge.
  always_comb begin
    w_div_next = '0;
    if (w_valid_next) w_div_next = base_div(w_code_next) >> w_oct_next;
  end

  // State and all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_code     <= NOTE_NONE;
      r_valid    <= 1'b0;
      r_start    <= 1'b0;
      r_octave   <= 2'(OCT_RESET);
      r_tone_div <= '0;
      r_up_d     <= 1'b0;
      r_dn_d     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_code     <= w_code_next;
      r_valid    <= w_valid_next;
      r_start    <= w_start_next;
      r_octave   <= w_oct_next;
      r_tone_div <= w_div_next;
      r_up_d     <= w_up;
      r_dn_d     <= w_dn;
    end
  end

`ifdef PIANO_SUSTAIN_EN
  // Release hold counter, cleared whenever the FSM is not sustaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sus_cnt <= '0;
    end else begin
      r_sus_cnt <= w_sus_next;
    end
  end
`endif

  assign note_valid = r_valid;
  assign note_code  = r_code;
  assign note_start = r_start;
  assign octave     = r_octave;
  assign tone_div   = r_tone_div;

endmodule
